// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module   : pc_seq_pkg
// Purpose  : Shared next-PC mode encoding and default address constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

  typedef enum logic [2:0] {
    PS_HOLD = 3'b000,
    PS_INC  = 3'b001,
    PS_ABS  = 3'b010,
    PS_REL  = 3'b011,
    PS_CALL = 3'b100,
    PS_RET  = 3'b101
  } ps_mode_e;

  localparam logic [63:0] C_RESET_ADDR = 64'h0000_0000_8000_0000;
  localparam logic [63:0] C_EXC_VECTOR = 64'h0000_0000_8000_0200;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// Module   : pc_ras
// Purpose  : Circular return-address LIFO; a push when full overwrites the
//            oldest entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ras #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  // ptr_q addresses the next free slot; the depth is a power of two so it wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push_i) begin
      ptr_q <= ptr_q + PTR_W'(1);
      if (cnt_q != C_DEPTH) cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_q <= ptr_q - PTR_W'(1);
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !reset) mem_q[ptr_q] <= data_i;
  end

  assign top_o   = mem_q[ptr_q - PTR_W'(1)];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == C_DEPTH);

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-stage program counter with six next-PC modes, exception
//            redirect, stall and misalignment flag. Optional RAS: PC_SEQ_RAS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(C_RESET_ADDR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(C_EXC_VECTOR),
  parameter int              INSN_SHIFT = 2,
  parameter int              RAS_DEPTH  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              exc_valid,
  input  logic [2:0]        PS,
  input  logic [ADDR_W-1:0] in,
  output logic [ADDR_W-1:0] out,
  output logic              misalign,
  output logic              ras_empty,
  output logic              ras_underflow
);

  localparam logic [ADDR_W-1:0] C_INC        = ADDR_W'(1) << INSN_SHIFT;
  localparam logic [ADDR_W-1:0] C_ALIGN_MASK = C_INC - ADDR_W'(1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              mis_q, mis_d;
  logic              unf_d;
  logic              push, pop;
  logic              rs_empty;
  logic [ADDR_W-1:0] rs_top;

  logic [ADDR_W-1:0] pc_inc, pc_rel, abs_tgt;
  logic              abs_mis;

  assign pc_inc  = pc_q + C_INC;
  assign pc_rel  = pc_q + (in << INSN_SHIFT);
  assign abs_tgt = in & ~C_ALIGN_MASK;
  assign abs_mis = |(in & C_ALIGN_MASK);

  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    unf_d = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    if (exc_valid) begin
      pc_d = EXC_VECTOR;
    end else if (!stall) begin
      case (PS)
        PS_INC:  pc_d = pc_inc;
        PS_ABS: begin
          pc_d  = abs_tgt;
          mis_d = abs_mis;
        end
        PS_REL:  pc_d = pc_rel;
`ifdef PC_SEQ_RAS_EN
        PS_CALL: begin
          pc_d = pc_rel;
          push = 1'b1;
        end
        PS_RET: begin
          if (!rs_empty) begin
            pc_d = rs_top;
            pop  = 1'b1;
          end else begin
            pc_d  = abs_tgt;
            mis_d = abs_mis;
            unf_d = 1'b1;
          end
        end
`else
        PS_CALL: pc_d = pc_rel;
        PS_RET: begin
          pc_d  = abs_tgt;
          mis_d = abs_mis;
        end
`endif
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= RESET_ADDR;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  assign out      = pc_q;
  assign misalign = mis_q;

`ifdef PC_SEQ_RAS_EN
  logic unf_q;
  logic unused_ras_full;

  always_ff @(posedge clock) begin
    if (reset) unf_q <= 1'b0;
    else       unf_q <= unf_d;
  end

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_inc),
    .top_o   (rs_top),
    .empty_o (rs_empty),
    .full_o  (unused_ras_full)
  );

  assign ras_empty     = rs_empty;
  assign ras_underflow = unf_q;
`else
  // Without the RAS the push/pop strobes and underflow term have no consumer.
  logic unused_ras;
  assign unused_ras    = ^{push, pop, unf_d, RAS_DEPTH[0]};
  assign rs_empty      = 1'b1;
  assign rs_top        = '0;
  assign ras_empty     = 1'b1;
  assign ras_underflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench: directed vector table, RAS depth sequence
//            and randomized run against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  localparam logic [63:0] RST_A = 64'h0000_0000_8000_0000;
  localparam logic [63:0] EXC_A = 64'h0000_0000_8000_0200;

  logic        clock = 1'b0;
  logic        reset, stall, exc_valid;
  logic [2:0]  PS;
  logic [63:0] in;
  logic [63:0] out;
  logic        misalign, ras_empty, ras_underflow;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .exc_valid     (exc_valid),
    .PS            (PS),
    .in            (in),
    .out           (out),
    .misalign      (misalign),
    .ras_empty     (ras_empty),
    .ras_underflow (ras_underflow)
  );

  always #5 clock = ~clock;

  // Reference model: return stack as a queue, newest entry at the back.
  logic [63:0] m_pc;
  logic [63:0] m_q[$];
  bit          m_mis, m_unf;

  task automatic model_step(input bit r, e, s, input logic [2:0] p, input logic [63:0] d);
    logic [63:0] aligned;
    aligned = {d[63:2], 2'b00};
    if (r) begin
      m_pc = RST_A; m_q.delete(); m_mis = 0; m_unf = 0;
    end else if (e) begin
      m_pc = EXC_A; m_mis = 0; m_unf = 0;
    end else begin
      m_mis = 0; m_unf = 0;
      if (!s) begin
        case (p)
          3'd1: m_pc = m_pc + 64'd4;
          3'd2: begin m_pc = aligned; m_mis = (d[1:0] != 0); end
          3'd3: m_pc = m_pc + (d << 2);
          3'd4: begin
            if (RAS) begin
              m_q.push_back(m_pc + 64'd4);
              if (m_q.size() > 8) void'(m_q.pop_front());
            end
            m_pc = m_pc + (d << 2);
          end
          3'd5: begin
            if (RAS && m_q.size() > 0) m_pc = m_q.pop_back();
            else begin
              m_pc = aligned; m_mis = (d[1:0] != 0); m_unf = RAS;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic drive(input bit r, e, s, input logic [2:0] p, input logic [63:0] d);
    reset = r; exc_valid = e; stall = s; PS = p; in = d;
    model_step(r, e, s, p, d);
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] eo, input bit em, ee, eu);
    checks += 4;
    if (out !== eo) begin
      errors++; $display("FAIL %s out: got %h expected %h", name, out, eo);
    end
    if (misalign !== em) begin
      errors++; $display("FAIL %s misalign: got %b expected %b", name, misalign, em);
    end
    if (ras_empty !== ee) begin
      errors++; $display("FAIL %s ras_empty: got %b expected %b", name, ras_empty, ee);
    end
    if (ras_underflow !== eu) begin
      errors++; $display("FAIL %s ras_underflow: got %b expected %b", name, ras_underflow, eu);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_pc, m_mis, RAS ? (m_q.size() == 0) : 1'b1, m_unf);
  endtask

  typedef struct {
    bit          r, e, s;
    logic [2:0]  p;
    logic [63:0] d;
    logic [63:0] eo;
    bit          em, ee, eu;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; stall = 0; exc_valid = 0; PS = 0; in = 0;

    tbl[0]  = '{1,0,0,3'd0, 64'h0,                  RST_A,                  0, 1, 0};
    tbl[1]  = '{0,0,0,3'd1, 64'h0,                  64'h8000_0004,          0, 1, 0};
    tbl[2]  = '{0,0,0,3'd1, 64'h0,                  64'h8000_0008,          0, 1, 0};
    tbl[3]  = '{0,0,0,3'd1, 64'h0,                  64'h8000_000C,          0, 1, 0};
    tbl[4]  = '{0,0,0,3'd1, 64'h0,                  64'h8000_0010,          0, 1, 0};
    tbl[5]  = '{0,0,0,3'd3, -64'sd2,                64'h8000_0008,          0, 1, 0};
    tbl[6]  = '{0,0,0,3'd2, 64'h1003,               64'h1000,               1, 1, 0};
    tbl[7]  = '{0,0,0,3'd0, 64'h0,                  64'h1000,               0, 1, 0};
    tbl[8]  = '{1,0,0,3'd0, 64'h0,                  RST_A,                  0, 1, 0};
    tbl[9]  = '{0,0,0,3'd4, 64'h40,                 64'h8000_0100,          0, !RAS, 0};
    tbl[10] = '{0,0,0,3'd5, 64'h8000_0004,          64'h8000_0004,          0, 1, 0};
    tbl[11] = '{0,0,1,3'd4, 64'h40,                 64'h8000_0004,          0, 1, 0};
    tbl[12] = '{0,1,1,3'd4, 64'h40,                 EXC_A,                  0, 1, 0};
    tbl[13] = '{0,0,0,3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0};
    tbl[14] = '{0,0,0,3'd1, 64'h0,                  64'h0,                  0, 1, 0};
    tbl[15] = '{0,0,0,3'd4, 64'h10,                 64'h40,                 0, !RAS, 0};
    tbl[16] = '{1,0,0,3'd4, 64'h10,                 RST_A,                  0, 1, 0};
    tbl[17] = '{0,0,0,3'd5, 64'h2002,               64'h2000,               1, 1, RAS};

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].p, tbl[i].d);
      check($sformatf("vec%0d", i), tbl[i].eo, tbl[i].em, tbl[i].ee, tbl[i].eu);
    end
    drive(0, 0, 0, 3'd6, 64'h1234);
    check("ps110_hold", 64'h2000, 0, 1, 0);

    // Nine calls overflow an 8-deep stack; nine returns then underflow once.
    drive(1, 0, 0, 3'd0, 64'h0);
    check_model("ras_reset");
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 0, 3'd4, 64'(k + 1));
      check_model($sformatf("call%0d", k));
    end
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 0, 3'd5, 64'h0000_0000_0000_5550 + 64'(k));
      check_model($sformatf("ret%0d", k));
    end
    checks++;
    if (ras_underflow !== RAS) begin
      errors++;
      $display("FAIL ninth_ret_underflow: got %b expected %b", ras_underflow, RAS);
    end

    // Randomized run.
    for (int n = 0; n < 400; n++) begin
      bit r, e, s;
      logic [2:0] p;
      logic [63:0] d;
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 7) == 0);
      p = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: d = {$urandom, $urandom};
        1: d = 64'($signed($urandom_range(0, 64)) - 32);
        default: d = {32'h0, $urandom};
      endcase
      drive(r, e, s, p, d);
      check_model($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
